// File: rtl/spi_reg_sequencer.sv
// spi_reg_sequencer
//   Register-access front end for the SPI master. Takes one read/write
//   register command at a time, packs it into a serial frame, runs the
//   master's PISO request/ack handshake, waits for the SIPO completion
//   pulse (or a timeout) and returns exactly one response per command.
//
// Ports
//   i_sys_clk, i_sys_rst_n        clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready       command handshake
//   i_cmd_rw/addr/wdata           command fields (rw: 1 = read)
//   o_rsp_valid/i_rsp_ready       response handshake
//   o_rsp_rdata, o_rsp_err        read data (0 for writes/timeouts), timeout flag
//   o_piso_data/xfer_size/req     frame, frame length and request to the master
//   i_piso_ack                    master accepted the request (pulse)
//   i_sipo_data, i_sipo_rdy       received frame and completion pulse
module spi_reg_sequencer #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 16,
    parameter int MAX_XFER_SIZE  = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                 i_sys_clk,
    input  logic                                 i_sys_rst_n,
    input  logic                                 i_cmd_valid,
    output logic                                 o_cmd_ready,
    input  logic                                 i_cmd_rw,
    input  logic [ADDR_WIDTH-1:0]                i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]                i_cmd_wdata,
    output logic                                 o_rsp_valid,
    input  logic                                 i_rsp_ready,
    output logic [DATA_WIDTH-1:0]                o_rsp_rdata,
    output logic                                 o_rsp_err,
    output logic [MAX_XFER_SIZE-1:0]             o_piso_data,
    output logic [$clog2(MAX_XFER_SIZE)-1:0]     o_piso_xfer_size,
    output logic                                 o_piso_req,
    input  logic                                 i_piso_ack,
    input  logic [MAX_XFER_SIZE-1:0]             i_sipo_data,
    input  logic                                 i_sipo_rdy
);
    localparam int XFER_CNT_WIDTH = $clog2(MAX_XFER_SIZE);
    localparam int FRAME_BITS     = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_WIDTH-1:0]       TO_LAST    = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [XFER_CNT_WIDTH-1:0] FRAME_SIZE = XFER_CNT_WIDTH'(FRAME_BITS);

    // The frame length must be expressible in the transfer-size field and
    // must fit on the master's data bus.
    generate
        if (FRAME_BITS > (2 ** XFER_CNT_WIDTH) - 1) begin : g_frame_size_check
            $error("FRAME_BITS does not fit in the transfer-size field");
        end
        if (FRAME_BITS > MAX_XFER_SIZE) begin : g_frame_bus_check
            $error("FRAME_BITS exceeds MAX_XFER_SIZE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DONE = 2'd2,
        RSP       = 2'd3
    } state_t;

    state_t                    state_reg, state_next;
    logic                      cmd_ready_reg, cmd_ready_next;
    logic                      rsp_valid_reg, rsp_valid_next;
    logic [DATA_WIDTH-1:0]     rsp_rdata_reg, rsp_rdata_next;
    logic                      rsp_err_reg, rsp_err_next;
    logic                      piso_req_reg, piso_req_next;
    logic [MAX_XFER_SIZE-1:0]  piso_data_reg, piso_data_next;
    logic [TO_WIDTH-1:0]       to_cnt_reg, to_cnt_next;

    logic [MAX_XFER_SIZE-1:0]  frame;
    logic [DATA_WIDTH-1:0]     sipo_payload;
    logic                      unused_sipo;

    // Frame: {data, addr, rw} from LSB upward; read frames carry zero data.
    always_comb begin
        frame                             = '0;
        frame[0]                          = i_cmd_rw;
        frame[ADDR_WIDTH:1]               = i_cmd_addr;
        frame[FRAME_BITS-1:ADDR_WIDTH+1]  = i_cmd_rw ? '0 : i_cmd_wdata;
    end

    assign sipo_payload = i_sipo_data[FRAME_BITS-1:ADDR_WIDTH+1];
    // Only the data field of the returned frame is meaningful.
    assign unused_sipo  = ^i_sipo_data;

    always_comb begin
        state_next     = state_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        piso_req_next  = piso_req_reg;
        piso_data_next = piso_data_reg;
        to_cnt_next    = to_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (i_cmd_valid && cmd_ready_reg) begin
                    piso_data_next = frame;
                    piso_req_next  = 1'b1;
                    to_cnt_next    = '0;
                    state_next     = REQ;
                end
            end
            REQ: begin
                to_cnt_next = to_cnt_reg + TO_WIDTH'(1);
                // Completion outranks timeout; a bare rdy without ack is stray.
                if (i_piso_ack && i_sipo_rdy) begin
                    piso_req_next  = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = piso_data_reg[0] ? sipo_payload : '0;
                    rsp_err_next   = 1'b0;
                    state_next     = RSP;
                end else if (to_cnt_reg == TO_LAST) begin
                    piso_req_next  = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                    state_next     = RSP;
                end else if (i_piso_ack) begin
                    piso_req_next  = 1'b0;
                    state_next     = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                to_cnt_next = to_cnt_reg + TO_WIDTH'(1);
                if (i_sipo_rdy) begin
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = piso_data_reg[0] ? sipo_payload : '0;
                    rsp_err_next   = 1'b0;
                    state_next     = RSP;
                end else if (to_cnt_reg == TO_LAST) begin
                    piso_req_next  = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = '0;
                    rsp_err_next   = 1'b1;
                    state_next     = RSP;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Ready is registered so it tracks the state one cycle ahead.
        cmd_ready_next = (state_next == IDLE);
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            piso_req_reg  <= 1'b0;
            piso_data_reg <= '0;
            to_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= cmd_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
            piso_req_reg  <= piso_req_next;
            piso_data_reg <= piso_data_next;
            to_cnt_reg    <= to_cnt_next;
        end
    end

    assign o_cmd_ready      = cmd_ready_reg;
    assign o_rsp_valid      = rsp_valid_reg;
    assign o_rsp_rdata      = rsp_rdata_reg;
    assign o_rsp_err        = rsp_err_reg;
    assign o_piso_req       = piso_req_reg;
    assign o_piso_data      = piso_data_reg;
    assign o_piso_xfer_size = FRAME_SIZE;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// tb_spi_reg_sequencer
//   Self-checking bench for spi_reg_sequencer with a short timeout. A small
//   behavioural model computes expected frames and read data arithmetically.
module tb_spi_reg_sequencer;
    localparam int AW = 7;
    localparam int DW = 16;
    localparam int MX = 32;
    localparam int XW = 5;
    localparam int TO = 16;
    localparam int FB = 1 + AW + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_rw = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [MX-1:0] piso_data;
    logic [XW-1:0] piso_xfer_size;
    logic          piso_req;
    logic          piso_ack = 1'b0;
    logic [MX-1:0] sipo_data = '0;
    logic          sipo_rdy = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_reg_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_XFER_SIZE(MX), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rw(cmd_rw),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_piso_data(piso_data), .o_piso_xfer_size(piso_xfer_size), .o_piso_req(piso_req),
        .i_piso_ack(piso_ack), .i_sipo_data(sipo_data), .i_sipo_rdy(sipo_rdy)
    );

    // Reference model: frame = rw + 2*addr + 2^(AW+1)*wdata (wdata zero for reads).
    function automatic logic [MX-1:0] model_frame(input bit rw, input logic [AW-1:0] addr,
                                                  input logic [DW-1:0] wdata);
        longint unsigned f;
        f = longint'(rw) + longint'(addr) * 2 + (rw ? 0 : longint'(wdata)) * (longint'(1) << (AW + 1));
        return f[MX-1:0];
    endfunction

    // Read data is the DW-bit field above rw and addr in the returned frame.
    function automatic logic [DW-1:0] model_rdata(input bit rw, input logic [MX-1:0] sipo);
        longint unsigned v;
        v = rw ? (longint'(sipo) / (longint'(1) << (AW + 1))) % (longint'(1) << DW) : 0;
        return v[DW-1:0];
    endfunction

    // One complete command/response transaction with inline checking.
    task automatic xfer(input string name, input bit rw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [MX-1:0] sipo,
                        input int ack_dly, input bit same, input int done_dly, input int rsp_dly);
        logic [MX-1:0] ef;
        logic [DW-1:0] er;
        int e0;
        e0 = errors;
        ef = model_frame(rw, addr, wdata);
        er = model_rdata(rw, sipo);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s idle_cmd_ready got %b exp 1", name, cmd_ready); end
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wdata;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_wdata = DW'($urandom);
        checks++; if (piso_req !== 1'b1) begin errors++; $display("FAIL %s req_assert got %b exp 1", name, piso_req); end
        checks++; if (piso_data !== ef) begin errors++; $display("FAIL %s frame got %h exp %h", name, piso_data, ef); end
        checks++; if (piso_xfer_size !== XW'(FB)) begin errors++; $display("FAIL %s xfer_size got %0d exp %0d", name, piso_xfer_size, FB); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL %s busy_cmd_ready got %b exp 0", name, cmd_ready); end
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            checks++; if (piso_req !== 1'b1 || piso_data !== ef) begin errors++; $display("FAIL %s req_hold got %b/%h exp 1/%h", name, piso_req, piso_data, ef); end
        end
        piso_ack = 1'b1;
        if (same) begin sipo_rdy = 1'b1; sipo_data = sipo; end
        @(negedge clk);
        piso_ack = 1'b0; sipo_rdy = 1'b0;
        checks++; if (piso_req !== 1'b0) begin errors++; $display("FAIL %s req_drop got %b exp 0", name, piso_req); end
        if (!same) begin
            for (int i = 0; i < done_dly; i++) begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s early_rsp got %b exp 0", name, rsp_valid); end
                piso_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
                piso_ack = 1'b0;
            end
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s early_rsp got %b exp 0", name, rsp_valid); end
            sipo_rdy = 1'b1; sipo_data = sipo;
            @(negedge clk);
            sipo_rdy = 1'b0;
        end
        sipo_data = MX'($urandom);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL %s rsp_valid got %b exp 1", name, rsp_valid); end
        checks++; if (rsp_rdata !== er) begin errors++; $display("FAIL %s rdata got %h exp %h", name, rsp_rdata, er); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL %s err got %b exp 0", name, rsp_err); end
        for (int i = 0; i < rsp_dly; i++) begin
            // Offer a new command and stray pulses while the response waits.
            cmd_valid = 1'b1; sipo_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            sipo_rdy = 1'b0;
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== er || rsp_err !== 1'b0)
                begin errors++; $display("FAIL %s rsp_hold got %b/%h/%b exp 1/%h/0", name, rsp_valid, rsp_rdata, rsp_err, er); end
            checks++; if (cmd_ready !== 1'b0 || piso_req !== 1'b0) begin errors++; $display("FAIL %s bp_busy got ready=%b req=%b exp 0/0", name, cmd_ready, piso_req); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0; cmd_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s rsp_clear got %b exp 0", name, rsp_valid); end
        checks++; if (cmd_ready !== 1'b1 || piso_req !== 1'b0) begin errors++; $display("FAIL %s back_idle got ready=%b req=%b exp 1/0", name, cmd_ready, piso_req); end
        $display("XFER %-8s rw=%0d addr=%h wdata=%h frame=%h rdata=%h ackd=%0d same=%0d doned=%0d rspd=%0d %s",
                 name, rw, addr, wdata, ef, er, ack_dly, same, done_dly, rsp_dly, (errors == e0) ? "ok" : "bad");
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin errors++; $display("FAIL rst_rsp got %b/%b/%h exp 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
        checks++; if (piso_req !== 1'b0 || piso_data !== '0) begin errors++; $display("FAIL rst_piso got %b/%h exp 0/0", piso_req, piso_data); end
        checks++; if (piso_xfer_size !== XW'(FB)) begin errors++; $display("FAIL rst_xfer_size got %0d exp %0d", piso_xfer_size, FB); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", cmd_ready); end
        $display("RESET released cmd_ready=%b", cmd_ready);
    endtask

    task automatic test_write;
        xfer("write", 1'b0, 7'h15, 16'hBEEF, 32'h12345678, 2, 1'b0, 3, 0);
    endtask

    task automatic test_read;
        xfer("read", 1'b1, 7'h03, 16'h0000, 32'h00A5C000, 1, 1'b0, 2, 0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 24; n++)
            xfer("random", 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), MX'($urandom),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    endtask

    task automatic test_same_cycle;
        xfer("same_rd", 1'b1, AW'($urandom), DW'($urandom), MX'($urandom), 0, 1'b1, 0, 1);
        xfer("same_wr", 1'b0, AW'($urandom), DW'($urandom), MX'($urandom), 2, 1'b1, 0, 0);
    endtask

    task automatic test_back_to_back;
        xfer("bp_rd", 1'b1, 7'h7F, 16'h0000, 32'h00FFFF00, 0, 1'b0, 0, 10);
        xfer("bp_wr", 1'b0, 7'h00, 16'hFFFF, 32'hFFFFFFFF, 0, 1'b0, 0, 10);
    endtask

    task automatic test_stray;
        sipo_rdy = 1'b1; piso_ack = 1'b1; sipo_data = 32'hFFFFFFFF;
        @(negedge clk);
        sipo_rdy = 1'b0; piso_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rsp_valid !== 1'b0 || piso_req !== 1'b0 || cmd_ready !== 1'b1)
                begin errors++; $display("FAIL stray_idle got valid=%b req=%b ready=%b exp 0/0/1", rsp_valid, piso_req, cmd_ready); end
            @(negedge clk);
        end
        $display("STRAY idle pulses ignored");
    endtask

    task automatic test_timeout;
        int n;
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = AW'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == TO - 1) begin
                checks++; if (piso_req !== 1'b1) begin errors++; $display("FAIL to_req_before got %b exp 1", piso_req); end
            end
        end
        checks++; if (n !== TO) begin errors++; $display("FAIL to_latency got %0d exp %0d", n, TO); end
        checks++; if (piso_req !== 1'b0) begin errors++; $display("FAIL to_req_drop got %b exp 0", piso_req); end
        checks++; if (rsp_err !== 1'b1 || rsp_rdata !== '0) begin errors++; $display("FAIL to_rsp got err=%b rdata=%h exp 1/0", rsp_err, rsp_rdata); end
        sipo_rdy = 1'b1; sipo_data = 32'hFFFFFFFF;
        @(negedge clk);
        sipo_rdy = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== '0) begin errors++; $display("FAIL to_hold got %b/%b/%h exp 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        sipo_rdy = 1'b1; piso_ack = 1'b1;
        @(negedge clk);
        sipo_rdy = 1'b0; piso_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rsp_valid !== 1'b0 || piso_req !== 1'b0) begin errors++; $display("FAIL to_late_rsp got valid=%b req=%b exp 0/0", rsp_valid, piso_req); end
            @(negedge clk);
        end
        $display("TIMEOUT latency=%0d err=%b", n, rsp_err);
    endtask

    task automatic test_async_reset;
        // Reset while the request is outstanding.
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h2A; cmd_wdata = 16'h1234;
        @(negedge clk);
        cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (piso_req !== 1'b0 || piso_data !== '0 || cmd_ready !== 1'b0)
            begin errors++; $display("FAIL arst_req got req=%b data=%h ready=%b exp 0/0/0", piso_req, piso_data, cmd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || piso_req !== 1'b0) begin errors++; $display("FAIL arst_release got ready=%b req=%b exp 1/0", cmd_ready, piso_req); end
        // Reset while in WAIT_DONE and then while holding a response.
        cmd_valid = 1'b1; cmd_rw = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; piso_ack = 1'b1;
        @(negedge clk);
        piso_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (piso_req !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL arst_wait got req=%b valid=%b exp 0/0", piso_req, rsp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; piso_ack = 1'b1; sipo_rdy = 1'b1; sipo_data = 32'hFFFFFFFF;
        @(negedge clk);
        piso_ack = 1'b0; sipo_rdy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0)
            begin errors++; $display("FAIL arst_rsp got %b/%h/%b exp 0/0/0", rsp_valid, rsp_rdata, rsp_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("ASYNC_RESET cleared req/rsp, resuming");
        xfer("post_rst", 1'b1, AW'($urandom), DW'($urandom), MX'($urandom), 1, 1'b0, 1, 1);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_random();
        test_same_cycle();
        test_back_to_back();
        test_stray();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
